// File: rtl/guess_datapath.sv
// Number-guessing game datapath: free-running secret value, synchronised
// guess, registered compare flags, held result LEDs and an optional
// remaining-attempts counter.
//
// Build option: define GUESS_DP_ATTEMPTS_EN to include the attempts counter.
// Without it, o_attempts_left is tied to MAX_ATTEMPTS and o_attempts_zero to 0.
module guess_datapath #(
  parameter int WIDTH        = 7,
  parameter int MAX_VALUE    = 99,
  parameter int MAX_ATTEMPTS = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_guess,
  input  logic             i_inc_actual,
  input  logic             i_update_leds,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic [2:0]       o_led,
  output logic [WIDTH-1:0] o_actual,
  output logic [3:0]       o_attempts_left,
  output logic             o_attempts_zero
);

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VALUE);
  localparam logic [3:0]       ATT_INIT = 4'(MAX_ATTEMPTS);

  logic [WIDTH-1:0] actual;
  logic [WIDTH-1:0] guess_q;

  // Secret value advances on request and wraps MAX_VALUE -> 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             actual <= '0;
    else if (i_inc_actual) actual <= (actual == MAX_V) ? '0 : actual + 1'b1;
  end

  // Switches are asynchronous to the game; one register stage brings them in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) guess_q <= '0;
    else       guess_q <= i_guess;
  end

  // Registered unsigned compare of the pre-edge guess and secret.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_over  <= 1'b0;
      o_under <= 1'b0;
      o_equal <= 1'b0;
    end else begin
      o_over  <= (guess_q >  actual);
      o_under <= (guess_q <  actual);
      o_equal <= (guess_q == actual);
    end
  end

  // LEDs capture the flags as they stand before the edge, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              o_led <= 3'b000;
    else if (i_update_leds) o_led <= {o_over, o_under, o_equal};
  end

  assign o_actual = actual;

`ifdef GUESS_DP_ATTEMPTS_EN
  logic [3:0] att_left;
  logic       att_zero;

  // Every LED update costs one attempt; the count saturates at zero and the
  // zero flag is registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      att_left <= ATT_INIT;
      att_zero <= 1'b0;
    end else if (i_update_leds && (att_left != 4'd0)) begin
      att_left <= att_left - 4'd1;
      att_zero <= (att_left == 4'd1);
    end
  end

  assign o_attempts_left = att_left;
  assign o_attempts_zero = att_zero;
`else
  assign o_attempts_left = ATT_INIT;
  assign o_attempts_zero = 1'b0;
`endif

endmodule

// File: tb/tb_guess_datapath.sv
// Directed bench for guess_datapath (default parameters). Expected values
// are hand-computed; the attempts expectations follow GUESS_DP_ATTEMPTS_EN.
module tb_guess_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] i_guess;
  logic       i_inc_actual;
  logic       i_update_leds;
  logic       o_over, o_under, o_equal;
  logic [2:0] o_led;
  logic [6:0] o_actual;
  logic [3:0] o_attempts_left;
  logic       o_attempts_zero;

  int total = 0;
  int bad   = 0;

  guess_datapath #(.WIDTH(7), .MAX_VALUE(99), .MAX_ATTEMPTS(7)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_guess         (i_guess),
    .i_inc_actual    (i_inc_actual),
    .i_update_leds   (i_update_leds),
    .o_over          (o_over),
    .o_under         (o_under),
    .o_equal         (o_equal),
    .o_led           (o_led),
    .o_actual        (o_actual),
    .o_attempts_left (o_attempts_left),
    .o_attempts_zero (o_attempts_zero)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    i_guess       = '0;
    i_inc_actual  = 1'b0;
    i_update_leds = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({o_over, o_under, o_equal, o_led, o_actual} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got flags=%b led=%b actual=%0d, want all 0",
               {o_over, o_under, o_equal}, o_led, o_actual);
    end
    total++;
    if (o_attempts_left !== 4'd7 || o_attempts_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_attempts: got left=%0d zero=%b, want 7/0", o_attempts_left, o_attempts_zero);
    end
    // Run a while so every register holds something non-reset.
    i_inc_actual  = 1'b1;
    i_update_leds = 1'b1;
    repeat (5) tick();
    i_inc_actual  = 1'b0;
    i_update_leds = 1'b0;
    total++;
    if (o_actual !== 7'd5 || o_led !== 3'b010 || o_under !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_run: got actual=%0d led=%b under=%b, want 5/010/1", o_actual, o_led, o_under);
    end
`ifdef GUESS_DP_ATTEMPTS_EN
    total++;
    if (o_attempts_left !== 4'd2) begin
      bad++;
      $display("FAIL pre_reset_attempts: got %0d want 2", o_attempts_left);
    end
`endif
    // Asynchronous reset: outputs clear without a clock edge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({o_over, o_under, o_equal, o_led, o_actual} !== 13'd0 ||
        o_attempts_left !== 4'd7 || o_attempts_zero !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got flags=%b led=%b actual=%0d left=%0d zero=%b",
               {o_over, o_under, o_equal}, o_led, o_actual, o_attempts_left, o_attempts_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset();
    i_inc_actual = 1'b1;
    repeat (99) tick();
    total++;
    if (o_actual !== 7'd99) begin
      bad++;
      $display("FAIL wrap_max: got %0d want 99", o_actual);
    end
    tick();
    total++;
    if (o_actual !== 7'd0) begin
      bad++;
      $display("FAIL wrap_zero: got %0d want 0", o_actual);
    end
    tick();
    total++;
    if (o_actual !== 7'd1) begin
      bad++;
      $display("FAIL wrap_101: got %0d want 1", o_actual);
    end
    i_inc_actual = 1'b0;
    tick();
    total++;
    if (o_actual !== 7'd1) begin
      bad++;
      $display("FAIL hold_actual: got %0d want 1", o_actual);
    end
  endtask

  task automatic test_compare;
    do_reset();
    i_inc_actual = 1'b1;
    repeat (42) tick();
    i_inc_actual = 1'b0;
    total++;
    if (o_actual !== 7'd42) begin
      bad++;
      $display("FAIL actual_42: got %0d want 42", o_actual);
    end
    // Guess 50: one edge later flags still reflect the old guess (0 < 42).
    i_guess = 7'd50;
    tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b010) begin
      bad++;
      $display("FAIL guess_latency1: got %b want 010", {o_over, o_under, o_equal});
    end
    tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b100) begin
      bad++;
      $display("FAIL over_50: got %b want 100", {o_over, o_under, o_equal});
    end
    i_guess = 7'd42;
    tick(); tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b001) begin
      bad++;
      $display("FAIL equal_42: got %b want 001", {o_over, o_under, o_equal});
    end
    i_guess = 7'd7;
    tick(); tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b010) begin
      bad++;
      $display("FAIL under_7: got %b want 010", {o_over, o_under, o_equal});
    end
    i_guess = 7'd127;
    tick(); tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b100) begin
      bad++;
      $display("FAIL over_127: got %b want 100", {o_over, o_under, o_equal});
    end
    // Secret change shows up on the flags one edge after actual moves.
    i_guess = 7'd42;
    tick(); tick();
    i_inc_actual = 1'b1;
    tick();
    i_inc_actual = 1'b0;
    total++;
    if (o_actual !== 7'd43 || {o_over, o_under, o_equal} !== 3'b001) begin
      bad++;
      $display("FAIL actual_latency0: got actual=%0d flags=%b want 43/001", o_actual, {o_over, o_under, o_equal});
    end
    tick();
    total++;
    if ({o_over, o_under, o_equal} !== 3'b010) begin
      bad++;
      $display("FAIL actual_latency1: got %b want 010", {o_over, o_under, o_equal});
    end
  endtask

  // Continues from test_compare: actual=43, guess=42, flags=under.
  task automatic test_leds;
    i_update_leds = 1'b1;
    tick();
    i_update_leds = 1'b0;
    total++;
    if (o_led !== 3'b010) begin
      bad++;
      $display("FAIL led_capture: got %b want 010", o_led);
    end
    i_guess = 7'd100;
    tick(); tick(); tick();
    total++;
    if (o_led !== 3'b010 || o_over !== 1'b1) begin
      bad++;
      $display("FAIL led_hold: got led=%b over=%b want 010/1", o_led, o_over);
    end
  endtask

  // Continues from test_leds: actual=43.
  task automatic test_simultaneous;
    i_guess = 7'd43;
    tick(); tick();
    total++;
    if (o_equal !== 1'b1) begin
      bad++;
      $display("FAIL sim_setup_equal: got %b want 1", o_equal);
    end
    i_inc_actual  = 1'b1;
    i_update_leds = 1'b1;
    tick();
    i_inc_actual  = 1'b0;
    total++;
    if (o_led !== 3'b001 || o_actual !== 7'd44) begin
      bad++;
      $display("FAIL inc_and_update: got led=%b actual=%0d want 001/44", o_led, o_actual);
    end
    // Update held: LEDs follow the flags edge by edge.
    tick();
    total++;
    if (o_led !== 3'b001 || o_under !== 1'b1) begin
      bad++;
      $display("FAIL track_edge2: got led=%b under=%b want 001/1", o_led, o_under);
    end
    tick();
    i_update_leds = 1'b0;
    total++;
    if (o_led !== 3'b010) begin
      bad++;
      $display("FAIL track_edge3: got %b want 010", o_led);
    end
  endtask

  task automatic test_attempts;
    logic [3:0] exp_left;
    logic       exp_zero;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      i_update_leds = 1'b1;
      tick();
      i_update_leds = 1'b0;
`ifdef GUESS_DP_ATTEMPTS_EN
      exp_left = (k >= 7) ? 4'd0 : 4'(7 - k);
      exp_zero = (k >= 7);
`else
      exp_left = 4'd7;
      exp_zero = 1'b0;
`endif
      total++;
      if (o_attempts_left !== exp_left || o_attempts_zero !== exp_zero) begin
        bad++;
        $display("FAIL attempts_pulse%0d: got left=%0d zero=%b want %0d/%b",
                 k, o_attempts_left, o_attempts_zero, exp_left, exp_zero);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_compare();
    test_leds();
    test_simultaneous();
    test_attempts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
